// File: rtl/ring_pkg.sv
// ring_pkg: checker state encodings and one-step ring rotation helper
package ring_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;
  function automatic logic [31:0] rot1(input logic [31:0] v, input int w, input int dir);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
    return dir != 0 ? (((v >> 1) | (v << (w - 1))) & m) : (((v << 1) | (v >> (w - 1))) & m);
  endfunction
endpackage

// File: rtl/ring_phase_checker_if.sv
// ring_phase_checker_if: phase sample bus and checker status; err_cnt exists only with RING_ERRCNT_EN
interface ring_phase_checker_if #(parameter int WIDTH = 4, parameter int REV_W = 8);
  logic [WIDTH-1:0]         phase_in;
  logic                     phase_vld;
  logic                     locked;
  logic                     err;
  logic [$clog2(WIDTH)-1:0] phase_idx;
  logic                     rev_tick;
  logic [REV_W-1:0]         rev_cnt;
`ifdef RING_ERRCNT_EN
  logic [7:0]               err_cnt;
  modport master (output phase_in, phase_vld, input locked, err, phase_idx, rev_tick, rev_cnt, err_cnt);
  modport slave (input phase_in, phase_vld, output locked, err, phase_idx, rev_tick, rev_cnt, err_cnt);
`else
  modport master (output phase_in, phase_vld, input locked, err, phase_idx, rev_tick, rev_cnt);
  modport slave (input phase_in, phase_vld, output locked, err, phase_idx, rev_tick, rev_cnt);
`endif
endinterface

// File: rtl/onehot_enc.sv
// onehot_enc: one-hot flag and set-bit index of a WIDTH-bit vector
module onehot_enc #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     oh,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int IW = $clog2(WIDTH);
  assign oh = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  // OR the positions of all set bits; exact whenever vec is one-hot
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = idx | (vec[i] ? IW'(i) : '0);
  end
endmodule

// File: rtl/ring_phase_checker.sv
// ring_phase_checker: one-hot ring rotation monitor with lock, revolution count and fault pulses; RING_ERRCNT_EN adds err_cnt
module ring_phase_checker
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int REV_W    = 8,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 2
) (
  input logic                clk,
  input logic                rst,
  ring_phase_checker_if.slave bus
);
  localparam int GW    = $clog2(LOCK_CNT + 1);
  localparam int START = DIR != 0 ? WIDTH - 1 : 0;
  state_t                   state;
  logic [WIDTH-1:0]         prev;
  logic [WIDTH-1:0]         expv;
  logic [GW-1:0]            good;
  logic                     oh;
  logic                     hit;
  logic                     fault;
  logic [$clog2(WIDTH)-1:0] idx;
  onehot_enc #(.WIDTH(WIDTH)) u_enc (.vec(bus.phase_in), .oh(oh), .idx(idx));
  assign expv  = WIDTH'(rot1(32'(prev), WIDTH, DIR));
  assign hit   = bus.phase_in == expv;
  assign fault = bus.phase_vld && state != IDLE && !hit;
  // acquisition/lock FSM with registered status, pulses and revolution count
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      prev          <= '0;
      good          <= '0;
      bus.locked    <= 1'b0;
      bus.err       <= 1'b0;
      bus.rev_tick  <= 1'b0;
      bus.phase_idx <= '0;
      bus.rev_cnt   <= '0;
    end else begin
      bus.err      <= fault;
      bus.rev_tick <= 1'b0;
      if (bus.phase_vld) begin
        if (oh) bus.phase_idx <= idx;
        if (state == IDLE) begin
          if (oh) begin
            state <= ACQ;
            prev  <= bus.phase_in;
            good  <= '0;
          end
        end else if (!hit) begin
          state      <= oh ? ACQ : IDLE;
          prev       <= bus.phase_in;
          good       <= '0;
          bus.locked <= 1'b0;
        end else if (state == ACQ) begin
          prev <= bus.phase_in;
          good <= good + GW'(1);
          if (32'(good) + 1 == LOCK_CNT) begin
            state       <= LOCKED;
            bus.locked  <= 1'b1;
            bus.rev_cnt <= '0;
          end
        end else begin
          prev <= bus.phase_in;
          if (bus.phase_in[START]) begin
            bus.rev_tick <= 1'b1;
            bus.rev_cnt  <= bus.rev_cnt + REV_W'(1);
          end
        end
      end
    end
`ifdef RING_ERRCNT_EN
  // count fault pulses, sticking at 255 until reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.err_cnt <= '0;
    else if (fault && bus.err_cnt != 8'hff) bus.err_cnt <= bus.err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_ring_phase_checker.sv
// tb_ring_phase_checker: directed scenarios plus randomized run against an index-based reference model
module tb_ring_phase_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int m_pidx, m_good, m_idx, m_rev, m_ecnt;
  logic m_locked, m_err, m_tick;
  localparam int LOCK = 2;
  ring_phase_checker_if #(.WIDTH(4), .REV_W(8)) bus ();
  ring_phase_checker #(.WIDTH(4), .REV_W(8), .DIR(0), .LOCK_CNT(LOCK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic model_reset();
    m_pidx = -1; m_good = 0; m_idx = 0; m_rev = 0; m_ecnt = 0;
    m_locked = 1'b0; m_err = 1'b0; m_tick = 1'b0;
  endtask
  task automatic model_step(input logic vld, input logic [3:0] v);
    int n, k;
    n = $countones(v);
    k = 0;
    for (int i = 0; i < 4; i++) if (v[i]) k = i;
    m_err = 1'b0;
    m_tick = 1'b0;
    if (!vld) return;
    if (n == 1) m_idx = k;
    if (m_pidx < 0) begin
      if (n == 1) begin m_pidx = k; m_good = 0; end
    end else if (n == 1 && k == (m_pidx + 1) % 4) begin
      m_pidx = k;
      if (m_locked) begin
        if (k == 0) begin m_tick = 1'b1; m_rev = (m_rev + 1) % 256; end
      end else begin
        m_good++;
        if (m_good == LOCK) begin m_locked = 1'b1; m_rev = 0; end
      end
    end else begin
      m_err = 1'b1;
      if (m_ecnt < 255) m_ecnt++;
      m_locked = 1'b0;
      m_good = 0;
      m_pidx = (n == 1) ? k : -1;
    end
  endtask
  task automatic step(input logic vld, input logic [3:0] v);
    bus.phase_vld = vld;
    bus.phase_in = v;
    model_step(vld, v);
    @(negedge clk);
  endtask
  task automatic test_reset();
    model_reset();
    bus.phase_vld = 1'b0;
    bus.phase_in = 4'b0000;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%0b exp=0", bus.locked); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    n_cmp++; if (bus.rev_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%0b exp=0", bus.rev_tick); end
    n_cmp++; if (bus.phase_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", bus.phase_idx); end
    n_cmp++; if (bus.rev_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_rev got=%0d exp=0", bus.rev_cnt); end
`ifdef RING_ERRCNT_EN
    n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt got=%0d exp=0", bus.err_cnt); end
`endif
    rst = 1'b1;
  endtask
  task automatic test_lock();
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0010);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL lock_early got=%0b exp=0", bus.locked); end
    step(1'b1, 4'b0100);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_locked got=%0b exp=1", bus.locked); end
    n_cmp++; if (bus.phase_idx !== 2'd2) begin n_bad++; $display("FAIL lock_idx got=%0d exp=2", bus.phase_idx); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL lock_err got=%0b exp=0", bus.err); end
  endtask
  task automatic test_revolution();
    int ticks;
    step(1'b1, 4'b1000);
    n_cmp++; if (bus.rev_tick !== 1'b0) begin n_bad++; $display("FAIL rev_early_tick got=%0b exp=0", bus.rev_tick); end
    step(1'b1, 4'b0001);
    n_cmp++; if (bus.rev_tick !== 1'b1) begin n_bad++; $display("FAIL rev_tick got=%0b exp=1", bus.rev_tick); end
    n_cmp++; if (bus.rev_cnt !== 8'd1) begin n_bad++; $display("FAIL rev_cnt got=%0d exp=1", bus.rev_cnt); end
    step(1'b1, 4'b0010);
    n_cmp++; if (bus.rev_tick !== 1'b0) begin n_bad++; $display("FAIL rev_tick_pulse got=%0b exp=0", bus.rev_tick); end
    ticks = 0;
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 4'b0100);
      step(1'b1, 4'b1000);
      step(1'b1, 4'b0001);
      if (bus.rev_tick === 1'b1) ticks++;
      step(1'b1, 4'b0010);
    end
    n_cmp++; if (ticks != 255) begin n_bad++; $display("FAIL rev_tick_count got=%0d exp=255", ticks); end
    n_cmp++; if (bus.rev_cnt !== 8'd0) begin n_bad++; $display("FAIL rev_wrap got=%0d exp=0", bus.rev_cnt); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL rev_locked got=%0b exp=1", bus.locked); end
  endtask
  task automatic test_skip();
    step(1'b1, 4'b0100);
    step(1'b1, 4'b1000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b1000);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL skip_err got=%0b exp=1", bus.err); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL skip_locked got=%0b exp=0", bus.locked); end
    n_cmp++; if (bus.rev_cnt !== 8'd1) begin n_bad++; $display("FAIL skip_rev_held got=%0d exp=1", bus.rev_cnt); end
    n_cmp++; if (bus.rev_tick !== 1'b0) begin n_bad++; $display("FAIL skip_tick got=%0b exp=0", bus.rev_tick); end
    step(1'b1, 4'b0001);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL skip_err_pulse got=%0b exp=0", bus.err); end
    step(1'b1, 4'b0010);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL skip_relock got=%0b exp=1", bus.locked); end
    n_cmp++; if (bus.rev_cnt !== 8'd0) begin n_bad++; $display("FAIL skip_relock_rev got=%0d exp=0", bus.rev_cnt); end
  endtask
  task automatic test_multihot();
    int errs;
    step(1'b1, 4'b0110);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL mh_err got=%0b exp=1", bus.err); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL mh_locked got=%0b exp=0", bus.locked); end
    n_cmp++; if (bus.phase_idx !== 2'd1) begin n_bad++; $display("FAIL mh_idx_held got=%0d exp=1", bus.phase_idx); end
    errs = 0;
    repeat (3) begin step(1'b1, 4'b0000); if (bus.err !== 1'b0) errs++; end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL idle_zero_err got=%0d exp=0", errs); end
    step(1'b1, 4'b0100);
    n_cmp++; if (bus.phase_idx !== 2'd2) begin n_bad++; $display("FAIL idle_acq_idx got=%0d exp=2", bus.phase_idx); end
    step(1'b1, 4'b1000);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL acq_follow_err got=%0b exp=0", bus.err); end
  endtask
  task automatic test_vld_gap();
    int bad;
    step(1'b1, 4'b0001);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL gap_prelock got=%0b exp=1", bus.locked); end
    bad = 0;
    repeat (5) begin
      step(1'b0, 4'b0001);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1 || bus.phase_idx !== 2'd0 || bus.rev_tick !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL gap_hold got=%0d exp=0", bad); end
    step(1'b1, 4'b0001);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL gap_repeat_err got=%0b exp=1", bus.err); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL gap_repeat_locked got=%0b exp=0", bus.locked); end
  endtask
  task automatic test_random();
    logic vld;
    logic [3:0] v;
    for (int i = 0; i < 800; i++) begin
      vld = $urandom_range(0, 3) != 0;
      v = (m_pidx >= 0 && $urandom_range(0, 9) < 7) ? 4'(1 << ((m_pidx + 1) % 4)) : 4'($urandom_range(0, 15));
      step(vld, v);
      n_cmp++; if (bus.locked !== m_locked) begin n_bad++; $display("FAIL rnd_locked i=%0d got=%0b exp=%0b", i, bus.locked, m_locked); end
      n_cmp++; if (bus.err !== m_err) begin n_bad++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, bus.err, m_err); end
      n_cmp++; if (bus.rev_tick !== m_tick) begin n_bad++; $display("FAIL rnd_tick i=%0d got=%0b exp=%0b", i, bus.rev_tick, m_tick); end
      n_cmp++; if (bus.phase_idx !== 2'(m_idx)) begin n_bad++; $display("FAIL rnd_idx i=%0d got=%0d exp=%0d", i, bus.phase_idx, m_idx); end
      n_cmp++; if (bus.rev_cnt !== 8'(m_rev)) begin n_bad++; $display("FAIL rnd_rev i=%0d got=%0d exp=%0d", i, bus.rev_cnt, m_rev); end
`ifdef RING_ERRCNT_EN
      n_cmp++; if (bus.err_cnt !== 8'(m_ecnt)) begin n_bad++; $display("FAIL rnd_errcnt i=%0d got=%0d exp=%0d", i, bus.err_cnt, m_ecnt); end
`endif
    end
  endtask
  task automatic test_async_reset();
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0100);
    step(1'b1, 4'b1000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0010);
    n_cmp++; if (bus.locked !== 1'b1 || bus.rev_cnt !== 8'd1) begin n_bad++; $display("FAIL arst_pre got=%0b/%0d exp=1/1", bus.locked, bus.rev_cnt); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked got=%0b exp=0", bus.locked); end
    n_cmp++; if (bus.rev_cnt !== 8'd0) begin n_bad++; $display("FAIL arst_rev got=%0d exp=0", bus.rev_cnt); end
    n_cmp++; if (bus.phase_idx !== 2'd0) begin n_bad++; $display("FAIL arst_idx got=%0d exp=0", bus.phase_idx); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b0 || bus.rev_tick !== 1'b0) begin n_bad++; $display("FAIL arst_pulses got=%0b/%0b exp=0/0", bus.err, bus.rev_tick); end
    rst = 1'b1;
    model_reset();
  endtask
`ifdef RING_ERRCNT_EN
  task automatic test_errcnt();
    step(1'b1, 4'b0001);
    repeat (300) step(1'b1, 4'b0001);
    n_cmp++; if (bus.err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt_sat got=%0d exp=255", bus.err_cnt); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL errcnt_err got=%0b exp=1", bus.err); end
  endtask
`endif
  initial begin
    test_reset();
    test_lock();
    test_revolution();
    test_skip();
    test_multihot();
    test_vld_gap();
    test_random();
    test_async_reset();
`ifdef RING_ERRCNT_EN
    test_errcnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
